// File: rtl/key_entry_ctrl.sv
// PS/2 set-2 scan-code sequencer building a BCD entry and handing operands to the datapath.
// Optional auto-repeat suppression: define KEY_TYPEMATIC_FILTER_EN.
module key_entry_ctrl #(
    parameter int MAX_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              byte_in,
    input  logic                    byte_valid,
    input  logic                    operand_ack,
    output logic [4*MAX_DIGITS-1:0] entry,
    output logic [2:0]              digit_count,
    output logic [4*MAX_DIGITS-1:0] operand,
    output logic                    operand_valid,
    output logic                    key_released,
    output logic [7:0]              released_code,
    output logic                    overflow
);

    localparam int         W       = 4 * MAX_DIGITS;
    localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BREAK, S_EXT_BREAK} state_t;

    state_t       r_state, w_state_nxt;
    logic [W-1:0] r_entry, w_entry_nxt;
    logic [2:0]   r_count, w_count_nxt;
    logic [W-1:0] r_operand, w_operand_nxt;
    logic         r_operand_valid, w_operand_valid_nxt;
    logic         r_key_released, w_key_released_nxt;
    logic [7:0]   r_released_code, w_released_code_nxt;
    logic         r_overflow, w_overflow_nxt;
    logic [7:0]   r_last_make, w_last_make_nxt;
    logic         w_make_act;
    logic         w_enter;
    logic         w_repeat;
    logic [4:0]   w_digit;

    // Returns {is_digit, bcd_value}.
    function automatic logic [4:0] decode_digit(input logic [7:0] code);
        case (code)
            8'h45:   return 5'h10;
            8'h16:   return 5'h11;
            8'h1E:   return 5'h12;
            8'h26:   return 5'h13;
            8'h25:   return 5'h14;
            8'h2E:   return 5'h15;
            8'h36:   return 5'h16;
            8'h3D:   return 5'h17;
            8'h3E:   return 5'h18;
            8'h46:   return 5'h19;
            default: return 5'h00;
        endcase
    endfunction

    assign w_digit = decode_digit(byte_in);

`ifdef KEY_TYPEMATIC_FILTER_EN
    assign w_repeat = (byte_in == r_last_make);
`else
    assign w_repeat = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no latch is inferred.
        w_state_nxt         = r_state;
        w_entry_nxt         = r_entry;
        w_count_nxt         = r_count;
        w_operand_nxt       = r_operand;
        w_operand_valid_nxt = r_operand_valid & ~operand_ack;
        w_key_released_nxt  = 1'b0;
        w_released_code_nxt = r_released_code;
        w_overflow_nxt      = 1'b0;
        w_last_make_nxt     = r_last_make;
        w_make_act          = 1'b0;
        w_enter             = 1'b0;

        if (byte_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (byte_in == 8'hE0) begin
                        w_state_nxt = S_EXT;
                    end else if (byte_in == 8'hF0) begin
                        w_state_nxt = S_BREAK;
                    end else if (!w_repeat) begin
                        w_last_make_nxt = byte_in;
                        w_make_act      = 1'b1;
                    end
                end
                S_EXT: begin
                    if (byte_in == 8'hF0) begin
                        w_state_nxt = S_EXT_BREAK;
                    end else if (byte_in != 8'hE0) begin
                        w_enter     = (byte_in == 8'h5A);
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    if (byte_in != 8'hF0 && byte_in != 8'hE0) begin
                        w_released_code_nxt = byte_in;
                        w_key_released_nxt  = 1'b1;
                        if (byte_in == r_last_make) w_last_make_nxt = 8'h00;
                        w_state_nxt = S_IDLE;
                    end
                end
            endcase
        end

        if (w_make_act) begin
            if (w_digit[4]) begin
                if (r_count < MAX_CNT) begin
                    w_entry_nxt = {r_entry[W-5:0], w_digit[3:0]};
                    w_count_nxt = r_count + 3'd1;
                end else begin
                    w_overflow_nxt = 1'b1;
                end
            end else begin
                case (byte_in)
                    8'h66: if (r_count != 3'd0) begin
                        w_entry_nxt = {4'h0, r_entry[W-1:4]};
                        w_count_nxt = r_count - 3'd1;
                    end
                    8'h76: begin
                        w_entry_nxt = '0;
                        w_count_nxt = 3'd0;
                    end
                    8'h5A:   w_enter = 1'b1;
                    default: ;
                endcase
            end
        end

        // A same-cycle ack frees the slot, so the new operand can load immediately.
        if (w_enter && (!r_operand_valid || operand_ack)) begin
            w_operand_nxt       = r_entry;
            w_operand_valid_nxt = 1'b1;
            w_entry_nxt         = '0;
            w_count_nxt         = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            r_state         <= S_IDLE;
            r_entry         <= '0;
            r_count         <= 3'd0;
            r_operand       <= '0;
            r_operand_valid <= 1'b0;
            r_key_released  <= 1'b0;
            r_released_code <= 8'h00;
            r_overflow      <= 1'b0;
            r_last_make     <= 8'h00;
        end else begin
            r_state         <= w_state_nxt;
            r_entry         <= w_entry_nxt;
            r_count         <= w_count_nxt;
            r_operand       <= w_operand_nxt;
            r_operand_valid <= w_operand_valid_nxt;
            r_key_released  <= w_key_released_nxt;
            r_released_code <= w_released_code_nxt;
            r_overflow      <= w_overflow_nxt;
            r_last_make     <= w_last_make_nxt;
        end
    end

    assign entry         = r_entry;
    assign digit_count   = r_count;
    assign operand       = r_operand;
    assign operand_valid = r_operand_valid;
    assign key_released  = r_key_released;
    assign released_code = r_released_code;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Table-driven bench for key_entry_ctrl (MAX_DIGITS=4); expectations follow KEY_TYPEMATIC_FILTER_EN.
module tb_key_entry_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        operand_ack;
    logic [15:0] entry;
    logic [2:0]  digit_count;
    logic [15:0] operand;
    logic        operand_valid;
    logic        key_released;
    logic [7:0]  released_code;
    logic        overflow;

    int total = 0;
    int bad   = 0;

`ifdef KEY_TYPEMATIC_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    typedef struct {
        logic        r;
        logic        bv;
        logic [7:0]  b;
        logic        ack;
        logic [15:0] e;
        logic [2:0]  c;
        logic [15:0] op;
        logic        opv;
        logic        kr;
        logic [7:0]  rc;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    key_entry_ctrl #(.MAX_DIGITS(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .byte_in       (byte_in),
        .byte_valid    (byte_valid),
        .operand_ack   (operand_ack),
        .entry         (entry),
        .digit_count   (digit_count),
        .operand       (operand),
        .operand_valid (operand_valid),
        .key_released  (key_released),
        .released_code (released_code),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic bv, input logic [7:0] b, input logic ack,
                       input logic [15:0] e, input logic [2:0] c, input logic [15:0] op,
                       input logic opv, input logic kr, input logic [7:0] rc, input logic ovf);
        vec_t v;
        v = '{r: r, bv: bv, b: b, ack: ack, e: e, c: c, op: op, opv: opv, kr: kr, rc: rc, ovf: ovf};
        vecs.push_back(v);
    endtask

    // One clock: drive on the falling edge, sample 1 ns after the rising edge.
    task automatic step(input logic r, input logic bv, input logic [7:0] b, input logic ack);
        @(negedge clk);
        rst         = r;
        byte_valid  = bv;
        byte_in     = b;
        operand_ack = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, ".entry"},  32'(entry),         32'(v.e));
        check({tag, ".count"},  32'(digit_count),   32'(v.c));
        check({tag, ".op"},     32'(operand),       32'(v.op));
        check({tag, ".opv"},    32'(operand_valid), 32'(v.opv));
        check({tag, ".kr"},     32'(key_released),  32'(v.kr));
        check({tag, ".rc"},     32'(released_code), 32'(v.rc));
        check({tag, ".ovf"},    32'(overflow),      32'(v.ovf));
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; byte_valid = 1'b0; byte_in = 8'h00; operand_ack = 1'b0;

        //   r  bv  byte  ack  entry    cnt  operand  opv kr rc     ovf
        add(1, 0, 8'h00, 0, 16'h0000, 0, 16'h0000, 0, 0, 8'h00, 0);
        // make/break sequences
        add(0, 1, 8'h16, 0, 16'h0001, 1, 16'h0000, 0, 0, 8'h00, 0);
        add(0, 1, 8'hF0, 0, 16'h0001, 1, 16'h0000, 0, 0, 8'h00, 0);
        add(0, 1, 8'h16, 0, 16'h0001, 1, 16'h0000, 0, 1, 8'h16, 0);
        add(0, 1, 8'h1E, 0, 16'h0012, 2, 16'h0000, 0, 0, 8'h16, 0);
        add(0, 1, 8'hF0, 0, 16'h0012, 2, 16'h0000, 0, 0, 8'h16, 0);
        add(0, 1, 8'h1E, 0, 16'h0012, 2, 16'h0000, 0, 1, 8'h1E, 0);
        // fill to MAX_DIGITS, then overflow
        add(0, 1, 8'h76, 0, 16'h0000, 0, 16'h0000, 0, 0, 8'h1E, 0);
        add(0, 1, 8'h16, 0, 16'h0001, 1, 16'h0000, 0, 0, 8'h1E, 0);
        add(0, 1, 8'h1E, 0, 16'h0012, 2, 16'h0000, 0, 0, 8'h1E, 0);
        add(0, 1, 8'h26, 0, 16'h0123, 3, 16'h0000, 0, 0, 8'h1E, 0);
        add(0, 1, 8'h25, 0, 16'h1234, 4, 16'h0000, 0, 0, 8'h1E, 0);
        add(0, 1, 8'h2E, 0, 16'h1234, 4, 16'h0000, 0, 0, 8'h1E, 1);
        // backspace / escape
        add(0, 1, 8'h76, 0, 16'h0000, 0, 16'h0000, 0, 0, 8'h1E, 0);
        add(0, 1, 8'h16, 0, 16'h0001, 1, 16'h0000, 0, 0, 8'h1E, 0);
        add(0, 1, 8'h1E, 0, 16'h0012, 2, 16'h0000, 0, 0, 8'h1E, 0);
        add(0, 1, 8'h26, 0, 16'h0123, 3, 16'h0000, 0, 0, 8'h1E, 0);
        add(0, 1, 8'h66, 0, 16'h0012, 2, 16'h0000, 0, 0, 8'h1E, 0);
        add(0, 1, 8'h76, 0, 16'h0000, 0, 16'h0000, 0, 0, 8'h1E, 0);
        add(0, 1, 8'h66, 0, 16'h0000, 0, 16'h0000, 0, 0, 8'h1E, 0);
        // enter and handshake
        add(0, 1, 8'h25, 0, 16'h0004, 1, 16'h0000, 0, 0, 8'h1E, 0);
        add(0, 1, 8'h1E, 0, 16'h0042, 2, 16'h0000, 0, 0, 8'h1E, 0);
        add(0, 1, 8'h5A, 0, 16'h0000, 0, 16'h0042, 1, 0, 8'h1E, 0);
        add(0, 1, 8'h3D, 0, 16'h0007, 1, 16'h0042, 1, 0, 8'h1E, 0);
        add(0, 1, 8'hE0, 0, 16'h0007, 1, 16'h0042, 1, 0, 8'h1E, 0);
        add(0, 1, 8'h5A, 0, 16'h0007, 1, 16'h0042, 1, 0, 8'h1E, 0);
        add(0, 1, 8'h5A, 1, 16'h0000, 0, 16'h0007, 1, 0, 8'h1E, 0);
        add(0, 0, 8'h00, 0, 16'h0000, 0, 16'h0007, 1, 0, 8'h1E, 0);
        add(0, 0, 8'h00, 1, 16'h0000, 0, 16'h0007, 0, 0, 8'h1E, 0);
        add(0, 1, 8'hE0, 0, 16'h0000, 0, 16'h0007, 0, 0, 8'h1E, 0);
        add(0, 1, 8'h5A, 0, 16'h0000, 0, 16'h0000, 1, 0, 8'h1E, 0);
        add(0, 0, 8'h00, 1, 16'h0000, 0, 16'h0000, 0, 0, 8'h1E, 0);
        // auto-repeat without break
        add(0, 1, 8'h16, 0, 16'h0001, 1, 16'h0000, 0, 0, 8'h1E, 0);
        add(0, 1, 8'h16, 0, FILT ? 16'h0001 : 16'h0011, FILT ? 3'd1 : 3'd2,
            16'h0000, 0, 0, 8'h1E, 0);
        add(0, 1, 8'h16, 0, FILT ? 16'h0001 : 16'h0111, FILT ? 3'd1 : 3'd3,
            16'h0000, 0, 0, 8'h1E, 0);
        add(0, 1, 8'h5A, 0, 16'h0000, 0, FILT ? 16'h0001 : 16'h0111, 1, 0, 8'h1E, 0);
        // reset in the middle of an extended break, pending operand lost
        add(0, 1, 8'hE0, 0, 16'h0000, 0, FILT ? 16'h0001 : 16'h0111, 1, 0, 8'h1E, 0);
        add(0, 1, 8'hF0, 0, 16'h0000, 0, FILT ? 16'h0001 : 16'h0111, 1, 0, 8'h1E, 0);
        add(1, 0, 8'h00, 0, 16'h0000, 0, 16'h0000, 0, 0, 8'h00, 0);
        add(0, 1, 8'h1E, 0, 16'h0002, 1, 16'h0000, 0, 0, 8'h00, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].r, vecs[i].bv, vecs[i].b, vecs[i].ack);
            check_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Extended non-enter make is ignored.
        step(0, 1, 8'hE0, 0);
        step(0, 1, 8'h16, 0);
        check("ext_other.entry", 32'(entry), 32'h0002);
        check("ext_other.count", 32'(digit_count), 32'd1);
        // Extended break releases a key without touching the entry.
        step(0, 1, 8'hE0, 0);
        step(0, 1, 8'hF0, 0);
        check("ext_brk.kr_before", 32'(key_released), 32'd0);
        step(0, 1, 8'h1E, 0);
        check("ext_brk.kr",    32'(key_released), 32'd1);
        check("ext_brk.rc",    32'(released_code), 32'h1E);
        check("ext_brk.entry", 32'(entry), 32'h0002);
        step(0, 0, 8'h00, 0);
        check("ext_brk.kr_pulse", 32'(key_released), 32'd0);
        // After the break the same key counts again even with the filter.
        step(0, 1, 8'h1E, 0);
        check("remake.entry", 32'(entry), 32'h0022);
        check("remake.count", 32'(digit_count), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
